// File: rtl/seq_pipe_add2_arb.sv
// Two requesters share one 2-stage adder: stage 1 adds the low half and keeps
// the carry, stage 2 adds the high half. Round-robin grant, tagged responses.
module seq_pipe_add2_arb #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic [NBITS-1:0] req0_in0,
  input  logic [NBITS-1:0] req0_in1,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic [NBITS-1:0] req1_in0,
  input  logic [NBITS-1:0] req1_in1,
  output logic             resp0_val,
  output logic [NBITS-1:0] resp0_out,
  output logic             resp1_val,
  output logic [NBITS-1:0] resp1_out,
  output logic             busy
);
  localparam int H      = NBITS / 2;
  localparam int STAGES = 2;

  typedef struct packed {
    logic         tag;
    logic         cy;
    logic [H-1:0] lo;
    logic [H-1:0] hi0;
    logic [H-1:0] hi1;
  } s1_t;

  typedef struct packed {
    logic             tag;
    logic [NBITS-1:0] sum;
  } s2_t;

  logic             prio;
  logic             xfer0, xfer1, xfer;
  logic [NBITS-1:0] op_a, op_b;
  logic [H:0]       lo_sum;
  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  s2_t              s2;

  // rdy never looks at its own port's val, so no val->rdy->val loop
  assign req0_rdy = ~prio | ~req1_val;
  assign req1_rdy =  prio | ~req0_val;
  assign xfer0    = req0_val & req0_rdy;
  assign xfer1    = req1_val & req1_rdy;
  assign xfer     = xfer0 | xfer1;

  assign op_a   = xfer1 ? req1_in0 : req0_in0;
  assign op_b   = xfer1 ? req1_in1 : req0_in1;
  assign lo_sum = {1'b0, op_a[H-1:0]} + {1'b0, op_b[H-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio     <= 1'b0;
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      // grant to 0 hands priority to 1 and vice versa; idle cycles hold it
      if (xfer) prio <= xfer0;
      vld_pipe <= {vld_pipe[1], xfer};
      if (xfer)
        s1 <= '{tag: xfer1, cy: lo_sum[H], lo: lo_sum[H-1:0],
                hi0: op_a[NBITS-1:H], hi1: op_b[NBITS-1:H]};
      if (vld_pipe[1])
        s2 <= '{tag: s1.tag, sum: {s1.hi0 + s1.hi1 + H'(s1.cy), s1.lo}};
    end
  end

  assign resp0_val = vld_pipe[2] & ~s2.tag;
  assign resp1_val = vld_pipe[2] &  s2.tag;
  assign resp0_out = resp0_val ? s2.sum : '0;
  assign resp1_out = resp1_val ? s2.sum : '0;
  assign busy      = |vld_pipe;

endmodule
